// File: rtl/hpio_link_ctrl.sv
// hpio_link_ctrl: HPIO native-PHY bring-up sequencer and loopback link checker
module hpio_link_ctrl #(
  parameter int LOCK_CNT  = 16,
  parameter int ERR_LIMIT = 4,
  parameter int TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        main_locked,
  input  logic        tx_locked,
  input  logic        rx_locked,
  input  logic        tx_seq_done,
  input  logic        rx_seq_done,
  input  logic        tx_dly_rdy,
  input  logic        rx_dly_rdy,
  input  logic        tx_vtc_rdy,
  input  logic        rx_vtc_rdy,
  output logic        en_vtc,
  output logic        gen_en,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [7:0]  rx_data,
  output logic [2:0]  rot,
  output logic        linked,
  output logic        fail,
  output logic [15:0] err_cnt,
  output logic [3:0]  state
);
  typedef enum logic [3:0] {IDLE, WAIT_LOCK, WAIT_SEQ, WAIT_DLY, WAIT_VTC, ALIGN, LINKED, FAIL} state_t;
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0]  ERR_LAST  = 8'(ERR_LIMIT - 1);
  localparam logic [19:0] TMO_LAST  = 20'(TIMEOUT - 1);
  state_t      st;
  logic [8:0]  meta, sync;
  logic [19:0] tmo;
  logic [7:0]  prev, good_cnt, bad_cnt;
  logic        vld, have_prev, locks_ok, lost, tmo_hit, good_word;
  function automatic logic [7:0] ror8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] d;
    d = {x, x} >> n;
    return d[7:0];
  endfunction
  assign locks_ok   = &sync[2:0];
  assign lost       = !locks_ok && st != IDLE && st != WAIT_LOCK && st != FAIL;
  assign tmo_hit    = tmo == TMO_LAST;
  assign good_word  = ror8(rx_data, rot) == ror8(prev, rot) + 8'd1;
  assign fifo_rd_en = (st == ALIGN || st == LINKED) && !fifo_empty;
  assign state      = st;
  // two-flop synchronizers for the status flags, plus the read-data valid strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      sync <= '0;
      vld  <= 1'b0;
    end else begin
      meta <= {rx_vtc_rdy, tx_vtc_rdy, rx_dly_rdy, tx_dly_rdy, rx_seq_done, tx_seq_done, rx_locked, tx_locked, main_locked};
      sync <= meta;
      vld  <= fifo_rd_en;
    end
  end
  // bring-up sequencer, rotation search and link monitor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      tmo       <= '0;
      en_vtc    <= 1'b0;
      gen_en    <= 1'b0;
      linked    <= 1'b0;
      fail      <= 1'b0;
      rot       <= '0;
      err_cnt   <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      prev      <= '0;
      have_prev <= 1'b0;
    end else begin
      tmo <= tmo + 20'd1;
      if (lost) begin
        st        <= WAIT_LOCK;
        tmo       <= '0;
        en_vtc    <= 1'b0;
        gen_en    <= 1'b0;
        linked    <= 1'b0;
        rot       <= '0;
        good_cnt  <= '0;
        bad_cnt   <= '0;
        have_prev <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            st  <= WAIT_LOCK;
            tmo <= '0;
          end
          WAIT_LOCK:
            if (locks_ok) begin
              st  <= WAIT_SEQ;
              tmo <= '0;
            end else if (tmo_hit) begin
              st   <= FAIL;
              fail <= 1'b1;
            end
          WAIT_SEQ:
            if (&sync[4:3]) begin
              st  <= WAIT_DLY;
              tmo <= '0;
            end else if (tmo_hit) begin
              st   <= FAIL;
              fail <= 1'b1;
            end
          WAIT_DLY:
            if (&sync[6:5]) begin
              st     <= WAIT_VTC;
              tmo    <= '0;
              en_vtc <= 1'b1;
            end else if (tmo_hit) begin
              st   <= FAIL;
              fail <= 1'b1;
            end
          WAIT_VTC:
            if (&sync[8:7]) begin
              st        <= ALIGN;
              tmo       <= '0;
              gen_en    <= 1'b1;
              good_cnt  <= '0;
              have_prev <= 1'b0;
            end else if (tmo_hit) begin
              st   <= FAIL;
              fail <= 1'b1;
            end
          ALIGN: begin
            if (vld) begin
              prev      <= rx_data;
              have_prev <= 1'b1;
              good_cnt  <= have_prev && good_word ? good_cnt + 8'd1 : 8'd0;
              if (have_prev && !good_word) rot <= rot + 3'd1;
            end
            if (vld && have_prev && good_word && good_cnt == LOCK_LAST) begin
              st      <= LINKED;
              tmo     <= '0;
              linked  <= 1'b1;
              bad_cnt <= '0;
            end else if (tmo_hit) begin
              st   <= FAIL;
              fail <= 1'b1;
            end
          end
          LINKED:
            if (vld) begin
              prev    <= rx_data;
              bad_cnt <= good_word ? 8'd0 : bad_cnt + 8'd1;
              if (!good_word && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
              if (!good_word && bad_cnt == ERR_LAST) begin
                st        <= ALIGN;
                tmo       <= '0;
                linked    <= 1'b0;
                good_cnt  <= '0;
                have_prev <= 1'b0;
              end
            end
          default: ;
        endcase
      end
    end
  end
endmodule
